nibble_bus_ctrl: RTL and testbench

Sequencer for a shared 4-bit tri-state bus that links NUM_REGS nibble registers, each with `load` and `out_en` strobes. It accepts one transfer command at a time over a req/ack handshake and generates one-hot `out_en` and `load` strobes so that at most one driver is ever on the bus. It also provides an external write path, an external read path and a clear operation. It sits between the front-panel/test logic and the nibble register bank.

---
 rtl/nibble_bus_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_nibble_bus_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_bus_ctrl.sv
// nibble_bus_ctrl: sequences one-hot out_en/load strobes on a shared 4-bit nibble bus.
// Define NIBBLE_BUS_TURN_EN to add an idle turnaround cycle after every command.
module nibble_bus_ctrl #(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req,
  input  logic [1:0]          i_op,
  input  logic [IDX_W-1:0]    i_src,
  input  logic [IDX_W-1:0]    i_dst,
  input  logic [3:0]          i_ext_data,
  input  logic [3:0]          i_bus_in,
  output logic                o_ack,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [NUM_REGS-1:0] o_load,
  output logic [NUM_REGS-1:0] o_out_en,
  output logic                o_drv_en,
  output logic [3:0]          o_drv_data,
  output logic [3:0]          o_rd_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_LATCH,
    ST_RELEASE,
    ST_TURN
  } state_t;

  localparam logic [1:0] OP_MOVE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t              r_state;
  state_t              w_state_next;

  logic [1:0]          r_op;
  logic [IDX_W-1:0]    r_src;
  logic [IDX_W-1:0]    r_dst;
  logic [3:0]          r_ext;
  logic                r_cmd_err;

  logic                r_ack;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [NUM_REGS-1:0] r_load;
  logic [NUM_REGS-1:0] r_out_en;
  logic                r_drv_en;
  logic [3:0]          r_drv_data;
  logic [3:0]          r_rd_data;
  logic                r_rd_cap;

  logic                w_accept;
  logic                w_src_bad;
  logic                w_dst_bad;
  logic                w_cmd_err;
  logic [NUM_REGS-1:0] w_src_hot;
  logic [NUM_REGS-1:0] w_dst_hot;
  logic                w_src_path;
  logic                w_drive_phase;
  logic                w_ack_next;
  logic                w_busy_next;
  logic                w_done_next;
  logic                w_err_next;
  logic [NUM_REGS-1:0] w_load_next;
  logic [NUM_REGS-1:0] w_out_en_next;
  logic                w_drv_en_next;
  logic [3:0]          w_drv_data_next;
  logic                w_rd_cap_next;

  // Validation looks at the live command inputs so the error decision is made at accept.
  assign w_src_bad = ((i_op == OP_MOVE) || (i_op == OP_READ)) && (32'(i_src) >= NUM_REGS);
  assign w_dst_bad = (i_op != OP_READ) && (32'(i_dst) >= NUM_REGS);
  assign w_cmd_err = w_src_bad || w_dst_bad || ((i_op == OP_MOVE) && (i_src == i_dst));

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_hot
    assign w_src_hot[gi] = (32'(r_src) == gi);
    assign w_dst_hot[gi] = (32'(r_dst) == gi);
  end

  assign w_src_path = (r_op == OP_MOVE) || (r_op == OP_READ);

  // Strobes are registered from the current state, so each phase reaches the pins
  // one cycle after the state register enters it.
  always_comb begin
    w_state_next    = r_state;
    w_accept        = 1'b0;
    w_ack_next      = 1'b0;
    w_busy_next     = 1'b0;
    w_done_next     = 1'b0;
    w_err_next      = 1'b0;
    w_load_next     = '0;
    w_out_en_next   = '0;
    w_drv_en_next   = 1'b0;
    w_drv_data_next = 4'b0000;
    w_rd_cap_next   = 1'b0;
    w_drive_phase   = (r_state == ST_DRIVE) || (r_state == ST_LATCH);

    case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          w_accept     = 1'b1;
          w_state_next = w_cmd_err ? ST_RELEASE : ST_DRIVE;
        end
      end
      ST_DRIVE:   w_state_next = ST_LATCH;
      ST_LATCH:   w_state_next = ST_RELEASE;
      ST_RELEASE: begin
`ifdef NIBBLE_BUS_TURN_EN
        w_state_next = ST_TURN;
`else
        w_state_next = ST_IDLE;
`endif
      end
      ST_TURN:    w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase

    w_ack_next  = w_accept;
    w_busy_next = w_accept || (r_state != ST_IDLE);
    w_done_next = (r_state == ST_RELEASE);
    w_err_next  = (r_state == ST_RELEASE) && r_cmd_err;

    if (w_drive_phase) begin
      if (w_src_path) begin
        w_out_en_next = w_src_hot;
      end else begin
        w_drv_en_next   = 1'b1;
        w_drv_data_next = (r_op == OP_WRITE) ? r_ext : 4'b0000;
      end
    end

    if (r_state == ST_LATCH) begin
      if (r_op == OP_READ) begin
        w_rd_cap_next = 1'b1;
      end else begin
        w_load_next = w_dst_hot;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_MOVE;
      r_src     <= '0;
      r_dst     <= '0;
      r_ext     <= 4'b0000;
      r_cmd_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op      <= i_op;
        r_src     <= i_src;
        r_dst     <= i_dst;
        r_ext     <= i_ext_data;
        r_cmd_err <= w_cmd_err;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_load     <= '0;
      r_out_en   <= '0;
      r_drv_en   <= 1'b0;
      r_drv_data <= 4'b0000;
      r_rd_cap   <= 1'b0;
      r_rd_data  <= 4'b0000;
    end else begin
      r_ack      <= w_ack_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_err      <= w_err_next;
      r_load     <= w_load_next;
      r_out_en   <= w_out_en_next;
      r_drv_en   <= w_drv_en_next;
      r_drv_data <= w_drv_data_next;
      r_rd_cap   <= w_rd_cap_next;
      // The source is still on the bus during the cycle r_rd_cap is high.
      if (r_rd_cap) begin
        r_rd_data <= i_bus_in;
      end
    end
  end

  assign o_ack      = r_ack;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_load     = r_load;
  assign o_out_en   = r_out_en;
  assign o_drv_en   = r_drv_en;
  assign o_drv_data = r_drv_data;
  assign o_rd_data  = r_rd_data;

endmodule

// File: tb/tb_nibble_bus_ctrl.sv
// Scoreboard bench for nibble_bus_ctrl: directed commands, a nibble-register bus model and a monitor.
module tb_nibble_bus_ctrl;

  localparam logic [1:0] OP_MOVE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
`ifdef NIBBLE_BUS_TURN_EN
  localparam int B2B_GAP = 5;
`else
  localparam int B2B_GAP = 4;
`endif

  logic       clk;
  logic       rst_n;
  logic       req;
  logic [1:0] op;
  logic [2:0] src;
  logic [2:0] dst;
  logic [3:0] ext_data;
  logic [3:0] bus_in;
  logic       ack, busy, done, err, drv_en;
  logic [3:0] load, out_en, drv_data, rd_data;

  nibble_bus_ctrl #(.NUM_REGS(4), .IDX_W(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_op(op), .i_src(src), .i_dst(dst),
    .i_ext_data(ext_data), .i_bus_in(bus_in), .o_ack(ack), .o_busy(busy), .o_done(done),
    .o_err(err), .o_load(load), .o_out_en(out_en), .o_drv_en(drv_en),
    .o_drv_data(drv_data), .o_rd_data(rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
  endtask

  // Register bank model: whoever is enabled drives the bus, load captures it.
  logic [3:0] regs [0:3];
  always_comb begin
    bus_in = 4'h0;
    if (drv_en) bus_in = drv_data;
    for (int i = 0; i < 4; i++) if (out_en[i]) bus_in = regs[i];
  end
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (load[i]) regs[i] <= bus_in;
  end

  typedef struct {
    logic       err;
    logic [3:0] oe;
    logic       drv;
    logic [3:0] dd;
    logic [3:0] ld;
    logic [3:0] rd;
    int         gap;
  } exp_t;
  exp_t sb_q[$];

  task automatic push(input logic e, input logic [3:0] oe, input logic drv, input logic [3:0] dd,
                      input logic [3:0] ld, input logic [3:0] rd, input int gap);
    exp_t x;
    x.err = e; x.oe = oe; x.drv = drv; x.dd = dd; x.ld = ld; x.rd = rd; x.gap = gap;
    sb_q.push_back(x);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [12:0] obs [0:7];
  int  k = 0;
  bit  active = 1'b0;
  int  ack_cyc = 0;
  int  prev_ack_cyc = 0;

  task automatic check_txn();
    exp_t e;
    logic [12:0] want;
    int bad;
    chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    chk("done_latency", 32'(k), e.err ? 32'd1 : 32'd3);
    chk("err_flag", 32'(err), 32'(e.err));
    chk("rd_data", 32'(rd_data), 32'(e.rd));
    bad = -1;
    for (int j = 0; j <= k; j++) begin
      want = 13'd0;
      if (!e.err && j == 1) want = {4'b0000, e.oe, e.drv, e.dd};
      if (!e.err && j == 2) want = {e.ld, e.oe, e.drv, e.dd};
      if (obs[j] !== want && bad < 0) bad = j;
    end
    if (bad < 0) chk("strobe_trace", 32'(obs[0]), 32'(obs[0]) & 32'h0);
    else chk($sformatf("strobe_trace_c%0d", bad), 32'(obs[bad]),
             (!e.err && bad == 1) ? 32'({4'b0000, e.oe, e.drv, e.dd}) :
             (!e.err && bad == 2) ? 32'({e.ld, e.oe, e.drv, e.dd}) : 32'd0);
    if (e.gap != 0) chk("ack_gap", 32'(ack_cyc - prev_ack_cyc), 32'(e.gap));
    $display("txn: ack@%0d err=%0b rd_data=%h latency=%0d", ack_cyc, err, rd_data, k);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      active = 1'b0;
    end else begin
      if (ack) begin
        chk("ack_while_active", 32'(active), 32'd0);
        prev_ack_cyc = ack_cyc;
        ack_cyc = cyc;
        active = 1'b1;
        k = 0;
      end
      if (active) begin
        obs[k] = {load, out_en, drv_en, drv_data};
        if (done) begin
          check_txn();
          active = 1'b0;
        end else if (k == 7) begin
          chk("done_timeout", 32'(done), 32'd1);
          active = 1'b0;
        end else begin
          k++;
        end
      end else begin
        chk("idle_done", 32'(done), 32'd0);
      end
    end
  end

  // Driver exclusivity, load only with one driver, drv_data quiet when not driving.
  always @(negedge clk) begin
    int drivers;
    bit ok;
    drivers = $countones(out_en) + int'(drv_en);
    ok = (drivers <= 1) && ((load == 4'b0) || (drivers == 1 && $onehot(load)))
         && (drv_en || drv_data == 4'h0);
    chk("bus_invariant", 32'(ok), 32'd1);
  end

  task automatic send(input logic [1:0] o, input logic [2:0] s, input logic [2:0] d,
                      input logic [3:0] x, input bit keep);
    int n;
    @(negedge clk);
    req = 1'b1; op = o; src = s; dst = d; ext_data = x;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 20);
    chk("ack_seen", 32'(ack), 32'd1);
    if (!keep) req = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("busy_drops", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req = 1'b0; op = 2'b00; src = 3'd0; dst = 3'd0; ext_data = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'({ack, busy, done, err, load, out_en, drv_en, drv_data, rd_data}), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    push(0, 4'b0000, 1, 4'hA, 4'b0100, 4'h0, 0); send(OP_WRITE, 3'd0, 3'd2, 4'hA, 0); wait_idle();
    push(0, 4'b0100, 0, 4'h0, 4'b0001, 4'h0, 0); send(OP_MOVE,  3'd2, 3'd0, 4'h0, 0); wait_idle();
    chk("r0_after_move", 32'(regs[0]), 32'hA);
    push(0, 4'b0100, 0, 4'h0, 4'b0000, 4'hA, 0); send(OP_READ,  3'd2, 3'd0, 4'h0, 0); wait_idle();
    push(0, 4'b0000, 1, 4'h5, 4'b0001, 4'hA, 0); send(OP_WRITE, 3'd0, 3'd0, 4'h5, 0); wait_idle();
    push(0, 4'b0001, 0, 4'h0, 4'b0000, 4'h5, 0); send(OP_READ,  3'd0, 3'd0, 4'h0, 0); wait_idle();
    push(1, 4'b0000, 0, 4'h0, 4'b0000, 4'h5, 0); send(OP_MOVE,  3'd1, 3'd1, 4'h0, 0); wait_idle();
    push(1, 4'b0000, 0, 4'h0, 4'b0000, 4'h5, 0); send(OP_CLEAR, 3'd0, 3'd5, 4'h0, 0); wait_idle();
    push(0, 4'b0000, 1, 4'h0, 4'b1000, 4'h5, 0); send(OP_CLEAR, 3'd0, 3'd3, 4'h9, 0); wait_idle();
    push(1, 4'b0000, 0, 4'h0, 4'b0000, 4'h5, 0); send(OP_READ,  3'd4, 3'd0, 4'h0, 0); wait_idle();

    push(0, 4'b0000, 1, 4'hC, 4'b0010, 4'h5, 0);       send(OP_WRITE, 3'd0, 3'd1, 4'hC, 1);
    push(0, 4'b0000, 1, 4'h3, 4'b1000, 4'h5, B2B_GAP); send(OP_WRITE, 3'd0, 3'd3, 4'h3, 0);
    wait_idle();
    push(0, 4'b0010, 0, 4'h0, 4'b0000, 4'hC, 0); send(OP_READ,  3'd1, 3'd0, 4'h0, 0); wait_idle();

    send(OP_MOVE, 3'd1, 3'd2, 4'h0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_load", 32'(load), 32'b0100);
    rst_n = 1'b0;
    #1;
    chk("reset_releases_bus", 32'({load, out_en, drv_en, busy, done}), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rd_after_reset", 32'(rd_data), 32'h0);

    push(0, 4'b0010, 0, 4'h0, 4'b0100, 4'h0, 0); send(OP_MOVE,  3'd1, 3'd2, 4'h0, 0); wait_idle();
    chk("r2_after_move", 32'(regs[2]), 32'hC);
    push(0, 4'b1000, 0, 4'h0, 4'b0000, 4'h3, 0); send(OP_READ,  3'd3, 3'd0, 4'h0, 0); wait_idle();

    n = 0;
    while ((sb_q.size() != 0 || active) && n < 20) begin
      @(posedge clk); n++;
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
